// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a shared byte-wide RAM; one 32-bit word = 4 byte cycles, big-endian.
// Optional MEM_ARB_RR_EN: round-robin on simultaneous requests instead of fixed data priority.
module mem_arbiter #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        busy
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] MAX_BASE = DW'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t        state, state_n;
  logic [1:0]    cnt, cnt_n;
  logic          owner_d, owner_d_n;
  logic          rw, rw_n;
  logic [AW-1:0] base, base_n;
  logic [DW-1:0] wdata, wdata_n;
  logic [DW-1:0] rword, rword_n;
  logic          last_d, last_d_n;

  logic          if_ack_n, if_err_n, d_ack_n, d_err_n;
  logic [DW-1:0] if_rdata_n, d_rdata_n;
  logic          ram_en_n, ram_rw_n, busy_n;
  logic [AW-1:0] ram_addr_n, ram_wdata_n;

  logic          prio_d, grant_d, bad;
  logic [DW-1:0] sel_addr, sel_wdata;
  logic          sel_rw;
  logic [1:0]    rsh, wsh;

  // Tie-break between simultaneous requests
`ifdef MEM_ARB_RR_EN
  assign prio_d = !last_d;
`else
  assign prio_d = 1'b1;
`endif

  assign grant_d   = d_req && (!if_req || prio_d);
  assign sel_addr  = grant_d ? d_addr : if_addr;
  assign sel_rw    = grant_d ? d_rw : 1'b0;
  assign sel_wdata = grant_d ? d_wdata : '0;
  assign bad       = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_BASE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner_d   <= 1'b0;
      rw        <= 1'b0;
      base      <= '0;
      wdata     <= '0;
      rword     <= '0;
      last_d    <= 1'b0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      ram_en    <= 1'b0;
      ram_rw    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      owner_d   <= owner_d_n;
      rw        <= rw_n;
      base      <= base_n;
      wdata     <= wdata_n;
      rword     <= rword_n;
      last_d    <= last_d_n;
      if_ack    <= if_ack_n;
      if_err    <= if_err_n;
      if_rdata  <= if_rdata_n;
      d_ack     <= d_ack_n;
      d_err     <= d_err_n;
      d_rdata   <= d_rdata_n;
      ram_en    <= ram_en_n;
      ram_rw    <= ram_rw_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
      busy      <= busy_n;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    owner_d_n   = owner_d;
    rw_n        = rw;
    base_n      = base;
    wdata_n     = wdata;
    rword_n     = rword;
    last_d_n    = last_d;
    if_ack_n    = 1'b0;
    if_err_n    = 1'b0;
    if_rdata_n  = if_rdata;
    d_ack_n     = 1'b0;
    d_err_n     = 1'b0;
    d_rdata_n   = d_rdata;
    ram_en_n    = 1'b0;
    ram_rw_n    = 1'b0;
    ram_addr_n  = '0;
    ram_wdata_n = '0;
    rsh         = 2'd3 - cnt;
    wsh         = 2'd0;

    case (state)
      IDLE: begin
        if (d_req || if_req) begin
          owner_d_n = grant_d;
          rw_n      = sel_rw;
          base_n    = sel_addr[AW-1:0];
          wdata_n   = sel_wdata;
          last_d_n  = grant_d;
          cnt_n     = '0;
          if (bad) begin
            state_n  = DONE;
            d_ack_n  = grant_d;
            d_err_n  = grant_d;
            if_ack_n = !grant_d;
            if_err_n = !grant_d;
          end else begin
            state_n     = XFER;
            ram_en_n    = 1'b1;
            ram_rw_n    = sel_rw;
            ram_addr_n  = sel_addr[AW-1:0];
            ram_wdata_n = sel_wdata[31:24];
          end
        end
      end
      XFER: begin
        if (!rw) rword_n[{rsh, 3'b000} +: 8] = ram_rdata;
        if (cnt == 2'd3) begin
          state_n  = DONE;
          d_ack_n  = owner_d;
          if_ack_n = !owner_d;
          if (!rw && owner_d)  d_rdata_n  = rword_n;
          if (!rw && !owner_d) if_rdata_n = rword_n;
        end else begin
          cnt_n       = cnt + 2'd1;
          wsh         = 2'd3 - cnt_n;
          ram_en_n    = 1'b1;
          ram_rw_n    = rw;
          ram_addr_n  = base + AW'(cnt_n);
          ram_wdata_n = wdata[{wsh, 3'b000} +: 8];
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
